key_fifo_ctrl: RTL
==================

Name: key_fifo_ctrl

Overview:
- Controller for the 8-deep, 8-bit keyboard byte FIFO.
- Write side: round-robin arbitration between two byte producers (port 0: scan-code encoder, port 1: host command/echo path), both writing into the FIFO.
- Read side: sequences FIFO pops, absorbs the FIFO's one-cycle registered read latency, and presents bytes to the downstream transmitter with a valid/ready handshake.
- Also provides an almost-full watermark to throttle producers early.

Parameters:
- DATA_W, 8, byte width; must match the FIFO data width.
- CNT_W, 4, width of the FIFO occupancy count.
- AF_LEVEL, 6, occupancy at or above which af is asserted.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req0  in  1  port 0 write request; held until granted.
- data0  in  DATA_W  port 0 write byte.
- gnt0  out  1  port 0 accepted this cycle (combinational).
- req1  in  1  port 1 write request; held until granted.
- data1  in  DATA_W  port 1 write byte.
- gnt1  out  1  port 1 accepted this cycle (combinational).
- fifo_wr_en  out  1  FIFO write enable.
- fifo_din  out  DATA_W  FIFO write data.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_dout  in  DATA_W  FIFO registered read data.
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO full flag.
- fifo_cnt  in  CNT_W  FIFO occupancy.
- out_data  out  DATA_W  byte to transmitter.
- out_valid  out  1  out_data valid.
- out_ready  in  1  transmitter accepts.
- af  out  1  almost full: fifo_cnt >= AF_LEVEL (combinational).

Behaviour:
Interface:
- One clock, clk. Reset rst is synchronous and active-high.
- While rst is high, all registers clear on the next clk edge: prio=0, state=IDLE, out_data=0, out_valid=0.
- While rst is high, gnt0, gnt1, fifo_wr_en and fifo_rd_en are forced 0 combinationally.

Write arbiter (combinational grant, registered priority):
- fifo_wr_en = (req0|req1) & !fifo_full & !rst.
- Only req0 active: gnt0=1. Only req1 active: gnt1=1.
- Both active: grant goes to port prio.
- fifo_din = data of the granted port; data0 when nothing is granted.
- At most one gnt per cycle. No gnt while fifo_full is high; requesters hold req and data.
- prio update: on any grant to port k, prio <= ~k. Otherwise prio holds.
- A write in the same cycle as a FIFO read is legal; the FIFO handles it.

Read sequencer FSM, states IDLE, LOAD, SEND:
- IDLE:
  - fifo_rd_en = !fifo_empty.
  - If !fifo_empty, go to LOAD.
- LOAD:
  - fifo_dout now holds the popped byte.
  - out_data <= fifo_dout, out_valid <= 1, go to SEND.
- SEND:
  - out_valid stays 1; out_data stays stable.
  - On out_ready=1: out_valid <= 0.
  - If !fifo_empty in that same cycle: fifo_rd_en=1, go to LOAD (pop overlapped with handshake).
  - Otherwise go to IDLE.
  - While out_ready=0: hold, no pops.
- Latency: fifo_empty falls in cycle N → fifo_rd_en in cycle N → out_valid high from N+2.
- Sustained throughput: one byte per 2 cycles with out_ready held high.
- fifo_rd_en is never asserted while fifo_empty=1, nor in LOAD.
- Mid-operation reset: any popped but undelivered byte is discarded. Reset of the FIFO itself is handled at top level.

Decomposition:
- Package key_pkg holds: DATA_W, CNT_W, AF_LEVEL defaults, and the state encoding (IDLE=2'd0, LOAD=2'd1, SEND=2'd2).
- One natural sub-module: rr_arb2, the 2-way round-robin arbiter with the prio register.
- The read FSM stays in the top module.

Test Plan:
- Reset, then FIFO empty with no requests → all outputs 0, state IDLE, no rd_en over 20 cycles.
- req0 with data0=8'h1C, FIFO empty → gnt0=1 and fifo_wr_en=1 with fifo_din=8'h1C in the same cycle. Model fifo_empty falling → rd_en the next cycle, out_valid and out_data=8'h1C two cycles later. out_ready=1 → out_valid drops.
- req0=req1=1 continuously, data0=8'hA0, data1=8'hB0 → grants alternate 0,1,0,1. FIFO contents A0,B0,A0,B0.
- fifo_full=1 with req1=1 → gnt1=0 and fifo_wr_en=0 while full. Drop full → gnt1=1 the same cycle. fifo_cnt=6 → af=1; fifo_cnt=5 → af=0.
- FIFO holds 3 bytes, out_ready=0 for 5 cycles then 1 → exactly one rd_en, out_data stable during stall. Then bytes 2 and 3 are delivered at a 2-cycle spacing.
- rst asserted in LOAD → next cycle out_valid=0 and state IDLE. No spurious rd_en while rst is high.

Source files
------------

// File: rtl/key_pkg.sv
// Shared sizing defaults and read-sequencer state encoding for the keyboard byte FIFO controller.
package key_pkg;
   localparam int DATA_W   = 8;
   localparam int CNT_W    = 4;
   localparam int AF_LEVEL = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } rd_state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grants, registered priority.
// Zero latency; hold_i (FIFO full) suppresses both grants so requesters keep waiting.
module rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic req0_i,
   input  logic req1_i,
   input  logic hold_i,
   output logic gnt0_o,
   output logic gnt1_o
);
   logic prio_q;
   logic prio_d;
   logic grant_ok;

   assign grant_ok = !hold_i && !rst;
   // prio only breaks ties; a lone requester always wins.
   assign gnt0_o   = grant_ok && req0_i && (!req1_i || !prio_q);
   assign gnt1_o   = grant_ok && req1_i && (!req0_i ||  prio_q);

   always_comb begin
      prio_d = prio_q;
      if (gnt0_o) begin
         prio_d = 1'b1;
      end else if (gnt1_o) begin
         prio_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end
endmodule

// File: rtl/key_fifo_ctrl.sv
// Keyboard byte FIFO controller: round-robin write arbitration, pop sequencing, almost-full flag.
// First byte reaches out_valid two cycles after pop; a stalled out_ready holds the byte and blocks pops.
module key_fifo_ctrl
   import key_pkg::*;
#(
   parameter int DATA_W   = key_pkg::DATA_W,
   parameter int CNT_W    = key_pkg::CNT_W,
   parameter int AF_LEVEL = key_pkg::AF_LEVEL
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [DATA_W-1:0] data0,
   output logic              gnt0,
   input  logic              req1,
   input  logic [DATA_W-1:0] data1,
   output logic              gnt1,
   output logic              fifo_wr_en,
   output logic [DATA_W-1:0] fifo_din,
   output logic              fifo_rd_en,
   input  logic [DATA_W-1:0] fifo_dout,
   input  logic              fifo_empty,
   input  logic              fifo_full,
   input  logic [CNT_W-1:0]  fifo_cnt,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              af
);
   rd_state_e         state_q;
   logic [DATA_W-1:0] out_data_q;
   logic              out_valid_q;
   logic              rd_en;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req0_i (req0),
      .req1_i (req1),
      .hold_i (fifo_full),
      .gnt0_o (gnt0),
      .gnt1_o (gnt1)
   );

   assign fifo_wr_en = (req0 || req1) && !fifo_full && !rst;
   assign fifo_din   = gnt1 ? data1 : data0;
   assign af         = (fifo_cnt >= CNT_W'(AF_LEVEL));

   // In SEND the next pop overlaps the handshake so the stream sustains one byte per two cycles.
   always_comb begin
      rd_en = 1'b0;
      case (state_q)
         IDLE:    rd_en = !fifo_empty;
         SEND:    rd_en = out_ready && !fifo_empty;
         default: rd_en = 1'b0;
      endcase
   end

   assign fifo_rd_en = rd_en && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) state_q <= LOAD;
            end
            LOAD: begin
               out_data_q  <= fifo_dout;
               out_valid_q <= 1'b1;
               state_q     <= SEND;
            end
            SEND: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= fifo_empty ? IDLE : LOAD;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
endmodule
